axi_single_burst_master: RTL and testbench
==========================================

// Module: axi_single_burst_master
// PURPOSE
//  AXI4 initiator issuing one INCR burst at a time (write: AW/W/B, read: AR/R) from a local
//  command port. Write data enters and read data leaves on valid/ready streams. One transaction
//  outstanding. It is the initiator counterpart of the per-slave NOC responder ports
//  (e.g. slave 3, 0x0000_6000-0x0000_6FFF) and drives a NOC master port.
// PARAMETERS
//  ID_W     4   AXI ID width
//  ADDR_W  32   address width
// PORTS
//  clk                      in   1       clock
//  rstn                     in   1       async active-low reset
//  cmd_valid/cmd_ready      in/out 1     command handshake
//  cmd_write                in   1       1=write, 0=read
//  cmd_addr                 in   ADDR_W  start byte address
//  cmd_len                  in   8       beats-1 (AXI LEN)
//  cmd_id                   in   ID_W    transaction ID
//  wd_valid/wd_ready        in/out 1     write-data stream handshake
//  wd_data / wd_strb        in   32/4    write beat data / byte strobes
//  rd_valid/rd_ready        out/in 1     read-data stream handshake
//  rd_data / rd_last        out  32/1    read beat data / final beat
//  done_valid               out  1       1-cycle completion pulse
//  done_resp / done_id      out  2/ID_W  final response / ID
//  awid,awaddr,awlen        out  ID_W/ADDR_W/8  write address (= cmd fields)
//  awsize,awburst,awvalid   out  3/2/1   const 3'b010, 2'b01 INCR; valid
//  awready                  in   1
//  wdata,wstrb,wlast,wvalid out  32/4/1/1
//  wready                   in   1
//  bid,bresp,bvalid         in   ID_W/2/1
//  bready                   out  1
//  arid,araddr,arlen,arsize,arburst,arvalid  out  as AW group
//  arready                  in   1
//  rid,rdata,rresp,rlast,rvalid  in  ID_W/32/2/1/1
//  rready                   out  1
//  Unlisted AXI sidebands (lock/cache/prot/qos/region) are tied to 0 at the top level.
// BEHAVIOUR
//  - FSM: IDLE, AW, W, B, AR, R, DONE. Async reset -> IDLE. All valid/ready outputs are 0,
//    except cmd_ready=1. All data outputs are 0. Outputs clear immediately on rstn low.
//    In-flight state is discarded.
//  - cmd_ready=1 only in IDLE. Accept on cmd_valid&&cmd_ready and register all cmd fields.
//  - Legality check at accept:
//    - cmd_addr[1:0]!=0, or cmd_addr[11:0]+(cmd_len+1)*4 > 4096 (4KB cross)
//      -> go to DONE. No AXI traffic. done_resp=2'b10.
//  - Legal write: IDLE->AW. awvalid=1 the next cycle, fields stable until awready.
//    - AW->W on the AW handshake. No W beat precedes AW.
//  - W state:
//    - wvalid=wd_valid; wd_ready=wready; wdata/wstrb=wd_data/wd_strb.
//    - An 8-bit beat counter increments per handshake. wlast=1 when count==len.
//    - Last-beat handshake -> B.
//  - B state: bready=1. On bvalid, done_resp=bresp, or 2'b10 if bid!=stored id. Then -> DONE.
//  - Legal read: IDLE->AR (same rules as AW). AR handshake -> R.
//  - R state:
//    - rready=rd_ready; rd_valid=rvalid; rd_data=rdata; rd_last=(count==len).
//    - done_resp tracks the max rresp seen.
//    - rlast!=(count==len), or rid!=id, forces done_resp=2'b10.
//    - The beat with count==len -> DONE. A missing rlast does not stall the FSM.
//  - DONE: done_valid=1 for exactly one cycle, done_id=stored id, then IDLE.
//    - Next command is accepted at earliest 2 cycles after the last AXI handshake.
//  - Zero-wait latency:
//    - accept->awvalid/arvalid: 1 cycle.
//    - final B/R handshake->done_valid: 1 cycle.
// TESTING
//  1. Write 0x6000, len=3, data 0x11..0x44, strb 0xF, zero wait -> 1 AW (awlen=3), 4 W beats,
//     wlast on beat 4 only, done_resp=00.
//  2. Read 0x6FF0, len=3, rresp=00 -> 4 rd beats, rd_last on beat 4, done_resp=00.
//     Then a read of 0x6FF4, len=3 -> no AR, done_resp=10 one cycle after accept.
//  3. Write with awready delayed 5 cycles and wready toggled per cycle -> awaddr and wdata
//     held stable while valid && !ready; beat count exact.
//  4. Read len=1 where the slave returns rresp=00,10 -> done_resp=10.
//     Read with rlast on beat 1 of len=1 -> done_resp=10.
//  5. Write with bid != awid -> done_resp=10. Write with bresp=11 -> done_resp=11.
//  6. Deassert rstn mid-W burst (beat 2 of 4) -> wvalid/awvalid drop asynchronously,
//     cmd_ready=1 after release, next command completes normally.

Source files
------------

// File: rtl/axi_single_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_single_burst_master
// Purpose  : AXI4 initiator that issues one INCR burst at a time (write via
//            AW/W/B, read via AR/R). Commands come from a local command port.
//            Write data enters, and read data leaves, on valid/ready streams.
// Revision : 1.0 - initial release
// ============================================================================
module axi_single_burst_master #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [ID_W-1:0]   cmd_id,
  // write-data stream
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [31:0]       wd_data,
  input  logic [3:0]        wd_strb,
  // read-data stream
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [31:0]       rd_data,
  output logic              rd_last,
  // completion
  output logic              done_valid,
  output logic [1:0]        done_resp,
  output logic [ID_W-1:0]   done_id,
  // AXI write address
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic [3:0]        awqos,
  output logic [3:0]        awregion,
  output logic              awvalid,
  input  logic              awready,
  // AXI write data
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  // AXI write response
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  // AXI read address
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic [3:0]        arqos,
  output logic [3:0]        arregion,
  output logic              arvalid,
  input  logic              arready,
  // AXI read data
  input  logic [ID_W-1:0]   rid,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   cur_id;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        cur_len;
  logic [7:0]        beat_cnt;
  logic [1:0]        max_resp;
  logic              resp_err;

  // End offset of the burst inside its 4KB page; 14 bits covers 4095 + 1024.
  logic [13:0] end_off;
  logic        illegal;
  logic        is_last;
  logic        w_hs;
  logic        r_hs;
  logic        r_beat_err;
  logic [1:0]  r_max;

  assign end_off    = {2'b00, cmd_addr[11:0]} + {4'b0000, cmd_len, 2'b00} + 14'd4;
  assign illegal    = (cmd_addr[1:0] != 2'b00) || (end_off > 14'd4096);
  assign is_last    = (beat_cnt == cur_len);
  assign w_hs       = (state == S_W) && wd_valid && wready;
  assign r_hs       = (state == S_R) && rvalid && rd_ready;
  assign r_beat_err = (rlast != is_last) || (rid != cur_id);
  assign r_max      = (rresp > max_resp) ? rresp : max_resp;

  // Control FSM: accepts a command, sequences the AXI channels, reports completion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      cur_id     <= '0;
      cur_addr   <= '0;
      cur_len    <= '0;
      beat_cnt   <= '0;
      max_resp   <= 2'b00;
      resp_err   <= 1'b0;
      awvalid    <= 1'b0;
      arvalid    <= 1'b0;
      done_valid <= 1'b0;
      done_resp  <= 2'b00;
      done_id    <= '0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cur_id   <= cmd_id;
            cur_addr <= cmd_addr;
            cur_len  <= cmd_len;
            beat_cnt <= '0;
            max_resp <= 2'b00;
            resp_err <= 1'b0;
            if (illegal) begin
              // Misaligned or page-crossing bursts never reach the bus.
              state      <= S_DONE;
              done_valid <= 1'b1;
              done_resp  <= 2'b10;
              done_id    <= cmd_id;
            end else if (cmd_write) begin
              state   <= S_AW;
              awvalid <= 1'b1;
            end else begin
              state   <= S_AR;
              arvalid <= 1'b1;
            end
          end
        end
        S_AW: begin
          if (awready) begin
            awvalid <= 1'b0;
            state   <= S_W;
          end
        end
        S_W: begin
          if (w_hs) begin
            if (is_last) state <= S_B;
            else         beat_cnt <= beat_cnt + 8'd1;
          end
        end
        S_B: begin
          if (bvalid) begin
            done_resp  <= (bid != cur_id) ? 2'b10 : bresp;
            done_id    <= cur_id;
            done_valid <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= S_R;
          end
        end
        S_R: begin
          if (r_hs) begin
            max_resp <= r_max;
            resp_err <= resp_err | r_beat_err;
            // Completion is driven by the local beat count, not by rlast.
            if (is_last) begin
              done_resp  <= (resp_err || r_beat_err) ? 2'b10 : r_max;
              done_id    <= cur_id;
              done_valid <= 1'b1;
              state      <= S_DONE;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == S_IDLE);

  assign awid     = cur_id;
  assign awaddr   = cur_addr;
  assign awlen    = cur_len;
  assign awsize   = 3'b010;
  assign awburst  = 2'b01;
  assign awlock   = 1'b0;
  assign awcache  = 4'b0000;
  assign awprot   = 3'b000;
  assign awqos    = 4'b0000;
  assign awregion = 4'b0000;

  assign arid     = cur_id;
  assign araddr   = cur_addr;
  assign arlen    = cur_len;
  assign arsize   = 3'b010;
  assign arburst  = 2'b01;
  assign arlock   = 1'b0;
  assign arcache  = 4'b0000;
  assign arprot   = 3'b000;
  assign arqos    = 4'b0000;
  assign arregion = 4'b0000;

  // Stream pass-through is gated by state so outputs fall with an async reset.
  assign wvalid   = (state == S_W) && wd_valid;
  assign wd_ready = (state == S_W) && wready;
  assign wdata    = (state == S_W) ? wd_data : 32'h0;
  assign wstrb    = (state == S_W) ? wd_strb : 4'h0;
  assign wlast    = (state == S_W) && is_last;
  assign bready   = (state == S_B);

  assign rready   = (state == S_R) && rd_ready;
  assign rd_valid = (state == S_R) && rvalid;
  assign rd_data  = (state == S_R) ? rdata : 32'h0;
  assign rd_last  = (state == S_R) && is_last;

endmodule
`default_nettype wire

// File: tb/tb_axi_single_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_single_burst_master
// Purpose  : Directed self-checking bench for axi_single_burst_master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_single_burst_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_id;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic [3:0]  done_id;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, arlock;
  logic [3:0]  awcache, arcache, awqos, arqos, awregion, arregion, wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;

  // observations filled by the stimulus tasks
  int          o_beats, o_addr_hs, o_stab_err, o_early, o_data_err, o_last_err, o_to;
  logic        o_lat, o_dv1, o_dv2, o_rdy1, o_rdy2;
  logic [1:0]  o_resp;
  logic [3:0]  o_id;
  logic [7:0]  o_len_seen;
  logic [31:0] o_addr_seen;

  axi_single_burst_master #(.ID_W(4), .ADDR_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done_valid(done_valid), .done_resp(done_resp), .done_id(done_id),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .awregion(awregion), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .arregion(arregion), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    o_beats = 0; o_addr_hs = 0; o_stab_err = 0; o_early = 0;
    o_data_err = 0; o_last_err = 0; o_to = 0;
    o_lat = 1'b0; o_dv1 = 1'b0; o_dv2 = 1'b0; o_rdy1 = 1'b0; o_rdy2 = 1'b0;
    o_resp = 2'b00; o_id = 4'h0; o_len_seen = 8'h00; o_addr_seen = 32'h0;
  endtask

  // Present a command and hold it until accepted; returns at posedge+1 after accept.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [7:0] l,
                       input logic [3:0] i);
    int cyc;
    bit hs;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_id = i;
    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 20) begin
      @(negedge clk);
      if (cmd_ready) hs = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    cmd_valid = 1'b0;
    if (!hs) o_to++;
  endtask

  task automatic finish_done();
    @(negedge clk);
    o_dv1 = done_valid; o_resp = done_resp; o_id = done_id; o_rdy1 = cmd_ready;
    @(posedge clk); #1;
    @(negedge clk);
    o_dv2 = done_valid; o_rdy2 = cmd_ready;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] l, input logic [3:0] i,
                          input int aw_delay, input bit toggle,
                          input logic [3:0] b_id, input logic [1:0] b_resp);
    int cyc;
    int beat;
    bit hs;
    clear_obs();
    issue(1'b1, a, l, i);
    o_lat = awvalid; o_addr_seen = awaddr; o_len_seen = awlen;
    wd_valid = 1'b1; wd_data = 32'h11; wd_strb = 4'hF;
    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 60) begin
      awready = (cyc >= aw_delay);
      @(negedge clk);
      if (awvalid && (awaddr !== a || awlen !== l || awid !== i)) o_stab_err++;
      if (wvalid) o_early++;
      if (awvalid && awready) begin hs = 1'b1; o_addr_hs++; end
      @(posedge clk); #1;
      cyc++;
    end
    if (!hs) o_to++;
    awready = 1'b0;
    beat = 0; cyc = 0;
    while (beat <= int'(l) && cyc < 100) begin
      wready  = toggle ? (cyc % 2 == 1) : 1'b1;
      wd_data = 32'h11 * (beat + 1);
      @(negedge clk);
      if (awvalid) o_addr_hs++;
      if (wvalid && (wdata !== 32'h11 * (beat + 1) || wstrb !== 4'hF)) o_data_err++;
      if (wvalid && (wlast !== (beat == int'(l)))) o_last_err++;
      if (wvalid && wready) beat++;
      @(posedge clk); #1;
      cyc++;
    end
    if (beat <= int'(l)) o_to++;
    o_beats = beat;
    wd_valid = 1'b0; wready = 1'b0;
    bid = b_id; bresp = b_resp; bvalid = 1'b1;
    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 20) begin
      @(negedge clk);
      if (bready) hs = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    bvalid = 1'b0;
    if (!hs) o_to++;
    finish_done();
  endtask

  // resps packs the per-beat RRESP, beat k in bits [2k+1:2k]; rlast_at<0 means never.
  task automatic do_read(input logic [31:0] a, input logic [7:0] l, input logic [3:0] i,
                         input logic [7:0] resps, input int rlast_at, input logic [3:0] r_id);
    int cyc;
    int beat;
    bit hs;
    clear_obs();
    issue(1'b0, a, l, i);
    o_lat = arvalid; o_addr_seen = araddr; o_len_seen = arlen;
    arready = 1'b1;
    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 20) begin
      @(negedge clk);
      if (awvalid || wvalid) o_early++;
      if (arvalid && arready) begin hs = 1'b1; o_addr_hs++; end
      @(posedge clk); #1;
      cyc++;
    end
    if (!hs) o_to++;
    arready = 1'b0;
    beat = 0; cyc = 0;
    rd_ready = 1'b1; rvalid = 1'b1; rid = r_id;
    while (beat <= int'(l) && cyc < 40) begin
      rdata = 32'hA0 + beat;
      rresp = resps[2*beat +: 2];
      rlast = (beat == rlast_at);
      @(negedge clk);
      if (arvalid) o_addr_hs++;
      if (rd_valid && rd_data !== 32'hA0 + beat) o_data_err++;
      if (rd_valid && (rd_last !== (beat == int'(l)))) o_last_err++;
      if (rvalid && rready) beat++;
      @(posedge clk); #1;
      cyc++;
    end
    if (beat <= int'(l)) o_to++;
    o_beats = beat;
    rvalid = 1'b0; rlast = 1'b0; rd_ready = 1'b0;
    finish_done();
  endtask

  task automatic test_reset();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if ({awvalid, arvalid, wvalid, bready, rready, rd_valid, done_valid, wd_ready} !== 8'h00) begin
      errors++; $display("FAIL rst_valids got %b exp 00000000", {awvalid, arvalid, wvalid, bready, rready, rd_valid, done_valid, wd_ready});
    end
    checks++; if ({awaddr, wdata, rd_data} !== 96'h0) begin errors++; $display("FAIL rst_data got %h exp 0", {awaddr, wdata, rd_data}); end
    checks++; if (done_resp !== 2'b00) begin errors++; $display("FAIL rst_done_resp got %b exp 00", done_resp); end
  endtask

  task automatic test_write_basic();
    do_write(32'h6000, 8'd3, 4'h3, 0, 1'b0, 4'h3, 2'b00);
    checks++; if (o_to !== 0) begin errors++; $display("FAIL wr1_timeout got %0d exp 0", o_to); end
    checks++; if (o_lat !== 1'b1) begin errors++; $display("FAIL wr1_aw_latency got %b exp 1", o_lat); end
    checks++; if (o_addr_seen !== 32'h6000 || o_len_seen !== 8'd3) begin errors++; $display("FAIL wr1_aw_fields got %h/%0d exp 6000/3", o_addr_seen, o_len_seen); end
    checks++; if (awsize !== 3'b010 || awburst !== 2'b01) begin errors++; $display("FAIL wr1_size_burst got %b/%b exp 010/01", awsize, awburst); end
    checks++; if (o_addr_hs !== 1 || o_early !== 0) begin errors++; $display("FAIL wr1_aw_count got %0d early %0d exp 1 early 0", o_addr_hs, o_early); end
    checks++; if (o_beats !== 4) begin errors++; $display("FAIL wr1_beats got %0d exp 4", o_beats); end
    checks++; if (o_data_err !== 0 || o_last_err !== 0) begin errors++; $display("FAIL wr1_data_last got %0d/%0d exp 0/0", o_data_err, o_last_err); end
    checks++; if (o_dv1 !== 1'b1 || o_dv2 !== 1'b0) begin errors++; $display("FAIL wr1_done_pulse got %b%b exp 10", o_dv1, o_dv2); end
    checks++; if (o_resp !== 2'b00 || o_id !== 4'h3) begin errors++; $display("FAIL wr1_done got %b/%h exp 00/3", o_resp, o_id); end
    checks++; if (o_rdy1 !== 1'b0 || o_rdy2 !== 1'b1) begin errors++; $display("FAIL wr1_cmd_ready got %b%b exp 01", o_rdy1, o_rdy2); end
  endtask

  task automatic test_read_basic();
    do_read(32'h6FF0, 8'd3, 4'h7, 8'h00, 3, 4'h7);
    checks++; if (o_to !== 0) begin errors++; $display("FAIL rd1_timeout got %0d exp 0", o_to); end
    checks++; if (o_lat !== 1'b1 || o_addr_seen !== 32'h6FF0 || o_len_seen !== 8'd3) begin errors++; $display("FAIL rd1_ar got %b %h %0d exp 1 6ff0 3", o_lat, o_addr_seen, o_len_seen); end
    checks++; if (o_addr_hs !== 1 || o_early !== 0) begin errors++; $display("FAIL rd1_ar_count got %0d/%0d exp 1/0", o_addr_hs, o_early); end
    checks++; if (o_beats !== 4 || o_data_err !== 0 || o_last_err !== 0) begin errors++; $display("FAIL rd1_beats got %0d/%0d/%0d exp 4/0/0", o_beats, o_data_err, o_last_err); end
    checks++; if (o_dv1 !== 1'b1 || o_dv2 !== 1'b0 || o_resp !== 2'b00 || o_id !== 4'h7) begin errors++; $display("FAIL rd1_done got %b%b %b %h exp 10 00 7", o_dv1, o_dv2, o_resp, o_id); end
  endtask

  task automatic test_illegal();
    // 0xFF4 + 16 bytes = 0x1004, crosses the 4KB page
    clear_obs();
    issue(1'b0, 32'h6FF4, 8'd3, 4'h2);
    @(negedge clk);
    checks++; if (arvalid !== 1'b0 || done_valid !== 1'b1 || done_resp !== 2'b10 || done_id !== 4'h2) begin
      errors++; $display("FAIL cross4k got ar=%b dv=%b resp=%b id=%h exp 0 1 10 2", arvalid, done_valid, done_resp, done_id);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (arvalid !== 1'b0 || done_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cross4k_after got ar=%b dv=%b rdy=%b exp 0 0 1", arvalid, done_valid, cmd_ready);
    end
    @(posedge clk); #1;
    // misaligned start address
    issue(1'b1, 32'h6002, 8'd0, 4'h6);
    @(negedge clk);
    checks++; if (awvalid !== 1'b0 || done_valid !== 1'b1 || done_resp !== 2'b10) begin
      errors++; $display("FAIL misaligned got aw=%b dv=%b resp=%b exp 0 1 10", awvalid, done_valid, done_resp);
    end
    checks++; if (o_to !== 0) begin errors++; $display("FAIL illegal_timeout got %0d exp 0", o_to); end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_stall();
    do_write(32'h6100, 8'd3, 4'h9, 5, 1'b1, 4'h9, 2'b00);
    checks++; if (o_to !== 0) begin errors++; $display("FAIL wrst_timeout got %0d exp 0", o_to); end
    checks++; if (o_stab_err !== 0 || o_addr_hs !== 1 || o_early !== 0) begin errors++; $display("FAIL wrst_aw got stab=%0d hs=%0d early=%0d exp 0 1 0", o_stab_err, o_addr_hs, o_early); end
    checks++; if (o_beats !== 4 || o_data_err !== 0 || o_last_err !== 0) begin errors++; $display("FAIL wrst_w got %0d/%0d/%0d exp 4/0/0", o_beats, o_data_err, o_last_err); end
    checks++; if (o_resp !== 2'b00 || o_dv1 !== 1'b1) begin errors++; $display("FAIL wrst_done got %b %b exp 00 1", o_resp, o_dv1); end
  endtask

  task automatic test_read_resp();
    do_read(32'h6200, 8'd1, 4'h4, 8'b0000_1000, 1, 4'h4);
    checks++; if (o_beats !== 2 || o_resp !== 2'b10 || o_dv1 !== 1'b1) begin errors++; $display("FAIL rd_slverr got %0d %b %b exp 2 10 1", o_beats, o_resp, o_dv1); end
    do_read(32'h6200, 8'd1, 4'h4, 8'b0000_0001, 1, 4'h4);
    checks++; if (o_resp !== 2'b01 || o_last_err !== 0) begin errors++; $display("FAIL rd_exokay got %b/%0d exp 01/0", o_resp, o_last_err); end
    do_read(32'h6200, 8'd1, 4'h4, 8'h00, 0, 4'h4);
    checks++; if (o_beats !== 2 || o_resp !== 2'b10 || o_to !== 0) begin errors++; $display("FAIL rd_early_rlast got %0d %b %0d exp 2 10 0", o_beats, o_resp, o_to); end
    do_read(32'h6200, 8'd1, 4'h4, 8'h00, 1, 4'h5);
    checks++; if (o_resp !== 2'b10) begin errors++; $display("FAIL rd_rid got %b exp 10", o_resp); end
  endtask

  task automatic test_bresp();
    do_write(32'h6300, 8'd1, 4'h5, 0, 1'b0, 4'h6, 2'b00);
    checks++; if (o_resp !== 2'b10 || o_id !== 4'h5) begin errors++; $display("FAIL wr_bid got %b/%h exp 10/5", o_resp, o_id); end
    do_write(32'h6FFC, 8'd0, 4'hA, 0, 1'b0, 4'hA, 2'b11);
    checks++; if (o_resp !== 2'b11 || o_beats !== 1 || o_last_err !== 0 || o_to !== 0) begin errors++; $display("FAIL wr_decerr got %b %0d %0d %0d exp 11 1 0 0", o_resp, o_beats, o_last_err, o_to); end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    issue(1'b1, 32'h6400, 8'd3, 4'h1);
    awready = 1'b1;
    @(posedge clk); #1;
    awready = 1'b0;
    wd_valid = 1'b1; wready = 1'b1; wd_data = 32'h11; wd_strb = 4'hF;
    @(posedge clk); #1;
    wready = 1'b0; wd_data = 32'h22;
    @(negedge clk);
    checks++; if (wvalid !== 1'b1 || wlast !== 1'b0) begin errors++; $display("FAIL rstmid_pre got wvalid=%b wlast=%b exp 1 0", wvalid, wlast); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (wvalid !== 1'b0 || awvalid !== 1'b0 || wdata !== 32'h0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_async got wv=%b awv=%b wd=%h rdy=%b exp 0 0 0 1", wvalid, awvalid, wdata, cmd_ready);
    end
    @(posedge clk); #1;
    wd_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", cmd_ready); end
    do_write(32'h6500, 8'd3, 4'h2, 0, 1'b0, 4'h2, 2'b00);
    checks++; if (o_beats !== 4 || o_resp !== 2'b00 || o_dv1 !== 1'b1 || o_to !== 0 || o_last_err !== 0) begin
      errors++; $display("FAIL rstmid_next got %0d %b %b %0d %0d exp 4 00 1 0 0", o_beats, o_resp, o_dv1, o_to, o_last_err);
    end
  endtask

  initial begin
    rstn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_len = 8'h0; cmd_id = 4'h0;
    wd_valid = 1'b0; wd_data = 32'h0; wd_strb = 4'h0; rd_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'h0; bresp = 2'b00; bvalid = 1'b0;
    arready = 1'b0; rid = 4'h0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    test_write_basic();
    test_read_basic();
    test_illegal();
    test_write_stall();
    test_read_resp();
    test_bresp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
